snake_step_engine: RTL

SNAKE_STEP_ENGINE -- requirements
Module: snake_step_engine

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_body_fifo.sv | 50 +++++
 rtl/snake_step_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake step engine: grid geometry, cell and
// direction codes, and the engine state enumeration.
package snake_pkg;

  localparam int unsigned GRID_W     = 32;
  localparam int unsigned GRID_H     = 20;
  localparam int unsigned GRID_CELLS = GRID_W * GRID_H;
  localparam int unsigned ADDR_W     = 10;

  localparam logic [1:0] CellEmpty = 2'b00;
  localparam logic [1:0] CellSnake = 2'b01;
  localparam logic [1:0] CellFood  = 2'b10;
  localparam logic [1:0] CellRsvd  = 2'b11;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirRight = 2'b01;
  localparam logic [1:0] DirDown  = 2'b10;
  localparam logic [1:0] DirLeft  = 2'b11;

  // Initial tail cell (14,10); the seed body occupies three ascending cells from here.
  localparam logic [ADDR_W-1:0] SEED_TAIL = ADDR_W'(10 * GRID_W + 14);

  typedef enum logic [3:0] {
    StClear,
    StSeed,
    StFoodRd,
    StFoodChk,
    StIdle,
    StCalc,
    StHeadRd,
    StHeadChk,
    StTailWr,
    StHeadWr,
    StDead
  } state_e;

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of snake body cell addresses; head is the newest entry,
// tail the oldest.
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  localparam int unsigned PtrW   = $clog2(MAX_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_head,
  output logic [ADDR_W-1:0] o_tail,
  output logic [PtrW:0]     o_count
);

  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] mem_q [MAX_LEN];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, head_ptr;
  logic [CntW-1:0]   count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_ptr = (wr_ptr_q == '0) ? PtrW'(MAX_LEN - 1) : wr_ptr_q - 1'b1;
  assign o_head   = mem_q[head_ptr];
  assign o_tail   = mem_q[rd_ptr_q];
  assign o_count  = count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (i_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(i_push) - CntW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/snake_step_engine.sv
// Snake game step engine: clears and seeds the grid RAM, places food from an
// LFSR, and advances the snake one cell per accepted tick.
module snake_step_engine
  import snake_pkg::*;
#(
  parameter int unsigned       MAX_LEN   = 64,
  parameter logic [ADDR_W-1:0] LFSR_SEED = 10'h2A5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic [1:0]        i_dir,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_write,
  output logic [1:0]        o_data,
  input  logic [1:0]        i_rdata,
  output logic              o_busy,
  output logic              o_game_over,
  output logic [7:0]        o_score
);

  localparam int unsigned CntW = $clog2(MAX_LEN) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [ADDR_W-1:0] nh_q, nh_d;
  logic [1:0]        dir_q, dir_d;
  logic              grow_q, grow_d;
  logic [7:0]        score_q, score_d;

  logic              wr, push, pop;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        data;
  logic [ADDR_W-1:0] body_head, body_tail;
  logic [CntW-1:0]   body_count;
  logic [4:0]        hx, hy, nx, ny;
  logic              hit;

  snake_body_fifo #(
    .MAX_LEN (MAX_LEN)
  ) u_body (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (addr),
    .o_head  (body_head),
    .o_tail  (body_tail),
    .o_count (body_count)
  );

  // x^10 + x^7 + 1
  assign lfsr_step = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  // GRID_W is 32, so the address splits as {y, x}.
  assign hx = body_head[4:0];
  assign hy = body_head[9:5];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    nh_d    = nh_q;
    dir_d   = dir_q;
    grow_d  = grow_q;
    score_d = score_q;
    wr      = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    addr    = '0;
    data    = CellEmpty;
    nx      = hx;
    ny      = hy;
    hit     = 1'b0;
    unique case (state_q)
      StClear: begin
        wr   = 1'b1;
        addr = cnt_q;
        if (cnt_q == ADDR_W'(GRID_CELLS - 1)) begin
          cnt_d   = '0;
          state_d = StSeed;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSeed: begin
        wr   = 1'b1;
        push = 1'b1;
        addr = SEED_TAIL + cnt_q;
        data = CellSnake;
        if (cnt_q == ADDR_W'(2)) begin
          cnt_d   = '0;
          dir_d   = DirRight;
          state_d = StFoodRd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFoodRd: begin
        if (lfsr_q < ADDR_W'(GRID_CELLS)) begin
          addr    = lfsr_q;
          state_d = StFoodChk;
        end else begin
          lfsr_d = lfsr_step;
        end
      end
      StFoodChk: begin
        if (i_rdata == CellEmpty) begin
          wr      = 1'b1;
          addr    = lfsr_q;
          data    = CellFood;
          state_d = StIdle;
        end else begin
          lfsr_d  = lfsr_step;
          state_d = StFoodRd;
        end
      end
      StIdle: begin
        if (i_tick) state_d = StCalc;
      end
      StCalc: begin
        dir_d = (i_dir == (dir_q ^ 2'b10)) ? dir_q : i_dir;
        case (dir_d)
          DirUp:    begin hit = (hy == 5'd0);             ny = hy - 5'd1; end
          DirRight: begin hit = (hx == 5'(GRID_W - 1));   nx = hx + 5'd1; end
          DirDown:  begin hit = (hy == 5'(GRID_H - 1));   ny = hy + 5'd1; end
          default:  begin hit = (hx == 5'd0);             nx = hx - 5'd1; end
        endcase
        nh_d    = {ny, nx};
        state_d = hit ? StDead : StHeadRd;
      end
      StHeadRd: begin
        addr    = nh_q;
        state_d = StHeadChk;
      end
      StHeadChk: begin
        // The tail cell still reads as snake here, so moving onto it is fatal.
        unique case (i_rdata)
          CellSnake, CellRsvd: state_d = StDead;
          CellFood: begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            grow_d  = 1'b1;
            state_d = StTailWr;
          end
          default: begin
            grow_d  = 1'b0;
            state_d = StTailWr;
          end
        endcase
      end
      StTailWr: begin
        if (!(grow_q && (body_count < CntW'(MAX_LEN)))) begin
          pop  = 1'b1;
          wr   = 1'b1;
          addr = body_tail;
        end
        state_d = StHeadWr;
      end
      StHeadWr: begin
        wr      = 1'b1;
        push    = 1'b1;
        addr    = nh_q;
        data    = CellSnake;
        state_d = grow_q ? StFoodRd : StIdle;
      end
      StDead: ;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      nh_q    <= '0;
      dir_q   <= DirRight;
      grow_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      nh_q    <= nh_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      score_q <= score_d;
    end
  end

  // Reset masks the RAM port at once so an in-flight write is dropped.
  assign o_write     = wr & ~i_rst;
  assign o_addr      = i_rst ? '0 : addr;
  assign o_data      = i_rst ? CellEmpty : data;
  assign o_busy      = (state_q != StIdle) && (state_q != StDead);
  assign o_game_over = (state_q == StDead) && !i_rst;
  assign o_score     = score_q;

endmodule
